// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, constants and helpers for the load/store unit.
//   lsu_state_t  : access FSM states
//   MASK_B/H/W   : request size masks (byte, half, word)
//   norm_mask    : any unsupported mask is treated as a word access
//   misaligned   : true when the low address bits break the size alignment
//   force_align  : clears the low address bits that break alignment
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_R,
        DONE
    } lsu_state_t;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] norm_mask(input logic [3:0] mask);
        return ((mask == MASK_B) || (mask == MASK_H)) ? mask : MASK_W;
    endfunction

    function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] off);
        case (mask)
            MASK_H:  return off[0];
            MASK_W:  return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [1:0] force_align(input logic [3:0] mask, input logic [1:0] off);
        case (mask)
            MASK_H:  return {off[1], 1'b0};
            MASK_W:  return 2'b00;
            default: return off;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: combinational byte-lane logic for the load/store unit.
// Ports:
//   mask       in  4   normalised size mask (MASK_B/H/W)
//   off        in  2   byte offset within the word (already alignment-adjusted)
//   sext       in  1   sign-extend byte/half loads
//   wdata      in  32  store data, LSBs significant
//   rdata      in  32  raw bus read word
//   be         out 4   byte enables = mask << off
//   lane_wdata out 32  store data replicated across all lanes of its size
//   load_data  out 32  extracted and extended load value
module lsu_align
    import lsu_pkg::*;
(
    input  logic [3:0]  mask,
    input  logic [1:0]  off,
    input  logic        sext,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [31:0] shifted;

    always_comb begin
        be         = mask << off;
        shifted    = rdata >> {off, 3'b000};
        lane_wdata = wdata;
        load_data  = shifted;
        case (mask)
            MASK_B: begin
                lane_wdata = {4{wdata[7:0]}};
                load_data  = {{24{sext & shifted[7]}}, shifted[7:0]};
            end
            MASK_H: begin
                lane_wdata = {2{wdata[15:0]}};
                load_data  = {{16{sext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                lane_wdata = wdata;
                load_data  = shifted;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: responder for core data-memory requests. Registers the
// request, runs one valid/ready bus transaction, aligns byte lanes, returns
// the extended load value and stalls the core until done_o.
// Optional build macro: LSU_MISALIGN_ERR_EN -- misaligned half/word requests
// skip the bus and complete with err_o. Without it the offending low address
// bits are forced to zero.
// Parameter: TIMEOUT_CYCLES (1..65535) max cycles in REQ+WAIT_R.
// Ports:
//   clk, reset_n_i                       clock, async active-low reset
//   req_valid_i/we/addr/mask/sext/wdata  core request
//   stall_o, done_o, rdata_o, err_o      core response
//   bus_valid_o/ready_i/we/addr/be/wdata bus command channel
//   bus_rvalid_i, bus_rdata_i            bus read return
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        req_valid_i,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [3:0]  req_mask_i,
    input  logic        req_sext_i,
    input  logic [31:0] req_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i
);

    lsu_state_t  state;
    logic        r_we;
    logic [29:0] r_word;
    logic [1:0]  r_off;
    logic [3:0]  r_mask;
    logic        r_sext;
    logic [31:0] r_wdata;
    logic [15:0] tmo_cnt;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        done_q;

    logic [3:0]  cap_mask;
    logic [1:0]  cap_off;
    logic        tmo_hit;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;

    assign cap_mask = norm_mask(req_mask_i);
`ifdef LSU_MISALIGN_ERR_EN
    assign cap_off  = req_addr_i[1:0];
`else
    assign cap_off  = force_align(cap_mask, req_addr_i[1:0]);
`endif

    // >= rather than == so a load accepted on the last allowed cycle still
    // times out in WAIT_R instead of waiting forever.
    assign tmo_hit = (({1'b0, tmo_cnt} + 17'd1) >= 17'(TIMEOUT_CYCLES));

    lsu_align u_align (
        .mask       (r_mask),
        .off        (r_off),
        .sext       (r_sext),
        .wdata      (r_wdata),
        .rdata      (bus_rdata_i),
        .be         (al_be),
        .lane_wdata (al_wdata),
        .load_data  (al_load)
    );

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            r_we    <= 1'b0;
            r_word  <= '0;
            r_off   <= '0;
            r_mask  <= '0;
            r_sext  <= 1'b0;
            r_wdata <= '0;
            tmo_cnt <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        r_we    <= req_we_i;
                        r_word  <= req_addr_i[31:2];
                        r_off   <= cap_off;
                        r_mask  <= cap_mask;
                        r_sext  <= req_sext_i;
                        r_wdata <= req_wdata_i;
                        tmo_cnt <= '0;
`ifdef LSU_MISALIGN_ERR_EN
                        if (misaligned(cap_mask, req_addr_i[1:0])) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state <= REQ;
                        end
`else
                        state <= REQ;
`endif
                    end
                end
                REQ: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (bus_ready_i) begin
                        if (r_we) begin
                            state   <= DONE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            rdata_q <= '0;
                        end else begin
                            state <= WAIT_R;
                        end
                    end else if (tmo_hit) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                WAIT_R: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    if (bus_rvalid_i) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= al_load;
                    end else if (tmo_hit) begin
                        state   <= DONE;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        case (state)
            IDLE:       stall_o = req_valid_i;
            REQ,
            WAIT_R:     stall_o = 1'b1;
            default:    stall_o = 1'b0;
        endcase
    end

    // Bus fields are only driven while the command is valid.
    assign bus_valid_o = (state == REQ);
    assign bus_we_o    = bus_valid_o & r_we;
    assign bus_addr_o  = bus_valid_o ? {r_word, 2'b00} : '0;
    assign bus_be_o    = bus_valid_o ? al_be : '0;
    assign bus_wdata_o = bus_valid_o ? al_wdata : '0;

    assign done_o  = done_q;
    assign err_o   = err_q;
    assign rdata_o = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic        req_valid_i;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [3:0]  req_mask_i;
    logic        req_sext_i;
    logic [31:0] req_wdata_i;
    logic        stall_o;
    logic        done_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        bus_valid_o;
    logic        bus_ready_i;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid_i;
    logic [31:0] bus_rdata_i;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .req_valid_i  (req_valid_i),
        .req_we_i     (req_we_i),
        .req_addr_i   (req_addr_i),
        .req_mask_i   (req_mask_i),
        .req_sext_i   (req_sext_i),
        .req_wdata_i  (req_wdata_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready_i),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  mask;
        logic        sext;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        int          rdy_dly;
        logic        exp_bus;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] mask,
                                input logic sext, input logic [31:0] wdata, input logic [31:0] brd,
                                input int dly, input logic ebus, input logic [31:0] eaddr,
                                input logic [3:0] ebe, input logic [31:0] ewd,
                                input logic [31:0] erd, input logic eerr);
        vec_t v;
        v.we = we; v.addr = addr; v.mask = mask; v.sext = sext; v.wdata = wdata;
        v.bus_rdata = brd; v.rdy_dly = dly; v.exp_bus = ebus; v.exp_addr = eaddr;
        v.exp_be = ebe; v.exp_wdata = ewd; v.exp_rdata = erd; v.exp_err = eerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic run_access(input vec_t v, input string tag, output int vcnt, output int cyc);
        logic        seen_bus, accepted, rv_sent, done_seen, unstable, stall_bad;
        logic [31:0] a0, w0, got_rdata;
        logic [3:0]  b0;
        logic        we0, got_err;
        seen_bus = 0; accepted = 0; rv_sent = 0; done_seen = 0; unstable = 0; stall_bad = 0;
        a0 = '0; w0 = '0; b0 = '0; we0 = 0; got_rdata = '0; got_err = 0;
        vcnt = 0; cyc = 0;
        @(negedge clk);
        req_valid_i = 1; req_we_i = v.we; req_addr_i = v.addr; req_mask_i = v.mask;
        req_sext_i = v.sext; req_wdata_i = v.wdata;
        #1;
        check({tag, "_stall_idle"}, {31'd0, stall_o}, 32'd1);
        while (!done_seen && cyc < 60) begin
            @(negedge clk);
            cyc++;
            bus_rvalid_i = 0;
            bus_rdata_i  = 32'h0BAD_0BAD;
            if (done_o) begin
                done_seen = 1; got_rdata = rdata_o; got_err = err_o;
                bus_ready_i = 0;
                if (stall_o) stall_bad = 1;
            end else begin
                if (!stall_o) stall_bad = 1;
                if (bus_valid_o) begin
                    if (!seen_bus) begin
                        a0 = bus_addr_o; b0 = bus_be_o; w0 = bus_wdata_o; we0 = bus_we_o;
                    end else if (a0 !== bus_addr_o || b0 !== bus_be_o ||
                                 w0 !== bus_wdata_o || we0 !== bus_we_o) begin
                        unstable = 1;
                    end
                    seen_bus = 1;
                    vcnt++;
                    bus_ready_i = (vcnt > v.rdy_dly);
                    if (bus_ready_i) accepted = 1;
                end else begin
                    bus_ready_i = 0;
                    if (accepted && !v.we && !rv_sent) begin
                        bus_rvalid_i = 1; bus_rdata_i = v.bus_rdata; rv_sent = 1;
                    end
                end
            end
        end
        req_valid_i = 0; bus_ready_i = 0; bus_rvalid_i = 0;
        check({tag, "_done"}, {31'd0, done_seen}, 32'd1);
        check({tag, "_bus_used"}, {31'd0, seen_bus}, {31'd0, v.exp_bus});
        if (v.exp_bus) begin
            check({tag, "_addr"}, a0, v.exp_addr);
            check({tag, "_be"}, {28'd0, b0}, {28'd0, v.exp_be});
            check({tag, "_we"}, {31'd0, we0}, {31'd0, v.we});
            if (v.we) check({tag, "_wdata"}, w0, v.exp_wdata);
            check({tag, "_stable"}, {31'd0, unstable}, 32'd0);
            if (v.rdy_dly == 0 && !v.exp_err)
                check({tag, "_latency"}, cyc, v.we ? 32'd2 : 32'd3);
        end
        check({tag, "_rdata"}, got_rdata, v.exp_rdata);
        check({tag, "_err"}, {31'd0, got_err}, {31'd0, v.exp_err});
        check({tag, "_stall"}, {31'd0, stall_bad}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int vc, cy;
        vec_t tv;
        //        we  addr          mask   sx wdata         bus_rdata     dly bus eaddr         ebe      ewdata        erdata        err
        vecs[0]  = mk(1, 32'h100, 4'b1111, 0, 32'hDEADBEEF, 32'h0,        0, 1, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0,        0);
        vecs[1]  = mk(1, 32'h103, 4'b0001, 0, 32'h000000A5, 32'h0,        3, 1, 32'h100, 4'b1000, 32'hA5A5A5A5, 32'h0,        0);
        vecs[2]  = mk(1, 32'h102, 4'b0011, 0, 32'h00001234, 32'h0,        0, 1, 32'h100, 4'b1100, 32'h12341234, 32'h0,        0);
        vecs[3]  = mk(0, 32'h101, 4'b0001, 1, 32'h0,        32'h00008000, 0, 1, 32'h100, 4'b0010, 32'h0,        32'hFFFFFF80, 0);
        vecs[4]  = mk(0, 32'h101, 4'b0001, 0, 32'h0,        32'h00008000, 0, 1, 32'h100, 4'b0010, 32'h0,        32'h00000080, 0);
        vecs[5]  = mk(0, 32'h102, 4'b0011, 1, 32'h0,        32'h80010000, 5, 1, 32'h100, 4'b1100, 32'h0,        32'hFFFF8001, 0);
        vecs[6]  = mk(0, 32'h102, 4'b0011, 0, 32'h0,        32'h80010000, 0, 1, 32'h100, 4'b1100, 32'h0,        32'h00008001, 0);
        vecs[7]  = mk(0, 32'h104, 4'b1111, 1, 32'h0,        32'h12345678, 0, 1, 32'h104, 4'b1111, 32'h0,        32'h12345678, 0);
        vecs[8]  = mk(1, 32'h108, 4'b0101, 0, 32'hCAFEF00D, 32'h0,        0, 1, 32'h108, 4'b1111, 32'hCAFEF00D, 32'h0,        0);
`ifdef LSU_MISALIGN_ERR_EN
        vecs[9]  = mk(0, 32'h102, 4'b1111, 0, 32'h0,        32'hA5A55A5A, 0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1);
        vecs[10] = mk(1, 32'h101, 4'b0011, 0, 32'h0000BEEF, 32'h0,        0, 0, 32'h0,   4'b0000, 32'h0,        32'h0,        1);
`else
        vecs[9]  = mk(0, 32'h102, 4'b1111, 0, 32'h0,        32'hA5A55A5A, 0, 1, 32'h100, 4'b1111, 32'h0,        32'hA5A55A5A, 0);
        vecs[10] = mk(1, 32'h101, 4'b0011, 0, 32'h0000BEEF, 32'h0,        0, 1, 32'h100, 4'b0011, 32'hBEEFBEEF, 32'h0,        0);
`endif
        vecs[11] = mk(0, 32'h203, 4'b0001, 1, 32'h0,        32'h7F000000, 2, 1, 32'h200, 4'b1000, 32'h0,        32'h0000007F, 0);

        reset_n_i = 0; req_valid_i = 0; req_we_i = 0; req_addr_i = '0; req_mask_i = '0;
        req_sext_i = 0; req_wdata_i = '0; bus_ready_i = 0; bus_rvalid_i = 0; bus_rdata_i = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {stall_o, done_o, err_o, bus_valid_o, bus_we_o, bus_be_o, 24'd0},
              32'd0);
        check("reset_rdata", rdata_o, 32'd0);
        check("reset_bus_addr", bus_addr_o, 32'd0);
        reset_n_i = 1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_access(vecs[i], $sformatf("v%0d", i), vc, cy);
            if (i == 5) check("v5_valid_cycles", vc, 32'd6);
        end

        // Ready never asserted: abort after 8 cycles in REQ.
        tv = mk(0, 32'h300, 4'b1111, 0, 32'h0, 32'h0, 1000, 1, 32'h300, 4'b1111, 32'h0, 32'h0, 1);
        run_access(tv, "tmo", vc, cy);
        check("tmo_valid_cycles", vc, 32'd8);
        @(negedge clk);
        check("tmo_valid_after", {31'd0, bus_valid_o}, 32'd0);
        check("tmo_done_after", {31'd0, done_o}, 32'd0);

        // Reset while waiting for read data.
        @(negedge clk);
        req_valid_i = 1; req_we_i = 0; req_addr_i = 32'h200; req_mask_i = 4'b1111; req_sext_i = 0;
        @(negedge clk);
        check("rst_req_valid", {31'd0, bus_valid_o}, 32'd1);
        bus_ready_i = 1;
        @(negedge clk);
        bus_ready_i = 0;
        req_valid_i = 0;
        check("rst_wait_state", {30'd0, bus_valid_o, stall_o}, 32'd1);
        #2 reset_n_i = 0;
        #1;
        check("rst_mid_outputs",
              {stall_o, done_o, err_o, bus_valid_o, bus_we_o, bus_be_o, 24'd0}, 32'd0);
        check("rst_mid_rdata", rdata_o, 32'd0);
        bus_rvalid_i = 1; bus_rdata_i = 32'hFFFFFFFF;
        @(negedge clk);
        reset_n_i = 1;
        @(negedge clk);
        check("rst_rvalid_ignored", {30'd0, done_o, stall_o}, 32'd0);
        @(negedge clk);
        check("rst_rvalid_ignored2", {30'd0, done_o, stall_o}, 32'd0);
        bus_rvalid_i = 0;
        run_access(vecs[7], "post_rst", vc, cy);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
